// File: rtl/attn_pkg.sv
// attn_pkg: shared types and constants for the attention output transmitter
package attn_pkg;
  localparam int SCORE_W = 9;
  localparam logic [1:0] TAG_SCORE = 2'b01;
  localparam logic [1:0] TAG_SUM = 2'b10;
  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI
`ifdef ATTN_TX_SUM_EN
    ,
    SUM_LO,
    SUM_HI
`endif
  } tx_state_t;
endpackage

// File: rtl/attn_sync_fifo.sv
// attn_sync_fifo: single-clock FIFO with same-cycle push/pop and occupancy count
module attn_sync_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
  // pointer and occupancy update; caller guarantees push only when room and pop only when non-empty
  always_comb begin
    mem_d = mem_q;
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (push) mem_d[wp_q] = din;
  end
  // storage is not reset; only the pointers and count define validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/attn_score_tx.sv
// attn_score_tx: buffers e^x scores and serializes them as tagged byte pairs; ATTN_TX_SUM_EN adds per-group sum frames
module attn_score_tx
  import attn_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GROUP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_vld_in,
  output logic [3:0]         credit_out,
  output logic [7:0]         data_mst_out,
  output logic               vld_mst_out,
  input  logic               rdy_mst_in,
  output logic               overflow_out
);
  localparam int CW = $clog2(DEPTH + 1);
  tx_state_t state_q, state_d;
  logic [CW-1:0] count;
  logic [SCORE_W-1:0] head;
  logic hs, pop, push_ok, more, ovf_q, ovf_d;
`ifdef ATTN_TX_SUM_EN
  localparam int GLOG = $clog2(GROUP);
  localparam int GW = GLOG > 0 ? GLOG : 1;
  localparam int SW = SCORE_W + GLOG;
  logic [SW-1:0] acc_q, acc_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [11:0] sum_ext;
  logic last;
  assign sum_ext = 12'(acc_q);
  assign last = grp_q == GW'(GROUP - 1);
`else
  if (GROUP < 1 || GROUP > 8) begin : g_group_unsupported
  end
`endif
  attn_sync_fifo #(.W(SCORE_W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push_ok),
    .pop(pop),
    .din(score_in),
    .dout(head),
    .count(count)
  );
  assign vld_mst_out = state_q != IDLE;
  assign hs = vld_mst_out & rdy_mst_in;
  assign pop = state_q == HI && hs;
  assign push_ok = score_vld_in && (count < CW'(DEPTH) || pop);
  assign more = count > CW'(1) || push_ok;
  assign credit_out = 4'(DEPTH) - 4'(count);
  assign overflow_out = ovf_q;
  // frame sequencing; the head is popped only on the score's second byte
  always_comb begin
    state_d = state_q;
    ovf_d = ovf_q | (score_vld_in & ~push_ok);
    case (state_q)
      IDLE: state_d = |count ? LO : IDLE;
      LO: state_d = hs ? HI : LO;
`ifdef ATTN_TX_SUM_EN
      HI: state_d = !hs ? HI : last ? SUM_LO : more ? LO : IDLE;
      SUM_LO: state_d = hs ? SUM_HI : SUM_LO;
      SUM_HI: state_d = !hs ? SUM_HI : |count ? LO : IDLE;
`else
      HI: state_d = !hs ? HI : more ? LO : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
`ifdef ATTN_TX_SUM_EN
  // accumulate each popped score; clear once the sum frame has been taken
  always_comb begin
    acc_d = pop ? acc_q + SW'(head) : acc_q;
    grp_d = pop ? grp_q + 1'b1 : grp_q;
    if (state_q == SUM_HI && hs) begin
      acc_d = '0;
      grp_d = '0;
    end
  end
  // byte mux; held stable because head and sum only change on the frame's last handshake
  always_comb begin
    data_mst_out = state_q == LO ? head[7:0] :
                   state_q == HI ? {TAG_SCORE, 5'b0, head[8]} :
                   state_q == SUM_LO ? sum_ext[7:0] :
                   state_q == SUM_HI ? {TAG_SUM, 2'b0, sum_ext[11:8]} : 8'h00;
  end
  // sum state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      grp_q <= '0;
    end else begin
      acc_q <= acc_d;
      grp_q <= grp_d;
    end
  end
`else
  // byte mux; held stable because head only changes on the frame's last handshake
  always_comb begin
    data_mst_out = state_q == LO ? head[7:0] :
                   state_q == HI ? {TAG_SCORE, 5'b0, head[8]} : 8'h00;
  end
`endif
  // state and sticky overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_attn_score_tx.sv
// tb_attn_score_tx: directed self-checking bench for attn_score_tx
module tb_attn_score_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8:0] score_in = '0;
  logic score_vld_in = 1'b0;
  logic [3:0] credit_out;
  logic [7:0] data_mst_out;
  logic vld_mst_out;
  logic rdy_mst_in = 1'b0;
  logic overflow_out;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  attn_score_tx #(.DEPTH(4), .GROUP(4)) dut (
    .clk(clk),
    .rst(rst),
    .score_in(score_in),
    .score_vld_in(score_vld_in),
    .credit_out(credit_out),
    .data_mst_out(data_mst_out),
    .vld_mst_out(vld_mst_out),
    .rdy_mst_in(rdy_mst_in),
    .overflow_out(overflow_out)
  );

  task automatic do_reset;
    rst = 1'b1;
    score_vld_in = 1'b0;
    score_in = '0;
    rdy_mst_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    n_tests++;
    if (credit_out !== 4'd4) begin n_fail++; $display("FAIL reset_credit got %0d want 4", credit_out); end
    n_tests++;
    if (vld_mst_out !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", vld_mst_out); end
    n_tests++;
    if (data_mst_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_mst_out); end
    n_tests++;
    if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow_out); end
  endtask

  task automatic test_single;
    do_reset();
    score_in = 9'h1A5;
    score_vld_in = 1'b1;
    rdy_mst_in = 1'b1;
    @(negedge clk);
    score_vld_in = 1'b0;
    n_tests++;
    if ({vld_mst_out, credit_out} !== {1'b0, 4'd3}) begin n_fail++; $display("FAIL single_queued got vld=%b credit=%0d want vld=0 credit=3", vld_mst_out, credit_out); end
    @(negedge clk);
    n_tests++;
    if ({vld_mst_out, data_mst_out} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL single_byte0 got vld=%b data=%h want vld=1 data=a5", vld_mst_out, data_mst_out); end
    @(negedge clk);
    n_tests++;
    if ({vld_mst_out, data_mst_out} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL single_byte1 got vld=%b data=%h want vld=1 data=41", vld_mst_out, data_mst_out); end
    @(negedge clk);
    n_tests++;
    if ({vld_mst_out, credit_out} !== {1'b0, 4'd4}) begin n_fail++; $display("FAIL single_done got vld=%b credit=%0d want vld=0 credit=4", vld_mst_out, credit_out); end
  endtask

  task automatic test_backpressure_overflow;
    logic [8:0] sc [4] = '{9'h040, 9'h0FF, 9'h100, 9'h1FF};
    logic [7:0] exp [8] = '{8'h40, 8'h40, 8'hFF, 8'h40, 8'h00, 8'h41, 8'hFF, 8'h41};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      score_in = sc[i];
      score_vld_in = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if ({credit_out, overflow_out} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL bp_full got credit=%0d ovf=%b want credit=0 ovf=0", credit_out, overflow_out); end
    score_in = 9'h0AA;
    @(negedge clk);
    score_vld_in = 1'b0;
    n_tests++;
    if ({credit_out, overflow_out} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL bp_overflow got credit=%0d ovf=%b want credit=0 ovf=1", credit_out, overflow_out); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({vld_mst_out, data_mst_out} !== {1'b1, 8'h40}) begin n_fail++; $display("FAIL bp_hold[%0d] got vld=%b data=%h want vld=1 data=40", i, vld_mst_out, data_mst_out); end
    end
    rdy_mst_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({vld_mst_out, data_mst_out} !== {1'b1, exp[i]}) begin n_fail++; $display("FAIL bp_stream[%0d] got vld=%b data=%h want vld=1 data=%h", i, vld_mst_out, data_mst_out, exp[i]); end
      @(negedge clk);
    end
    n_tests++;
    if ({vld_mst_out, credit_out, overflow_out} !== {1'b0, 4'd4, 1'b1}) begin n_fail++; $display("FAIL bp_drained got vld=%b credit=%0d ovf=%b want vld=0 credit=4 ovf=1", vld_mst_out, credit_out, overflow_out); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({vld_mst_out, overflow_out} !== 2'b01) begin n_fail++; $display("FAIL bp_no_extra[%0d] got vld=%b ovf=%b want vld=0 ovf=1", i, vld_mst_out, overflow_out); end
    end
    rdy_mst_in = 1'b0;
  endtask

  task automatic test_reset_midframe;
    do_reset();
    score_in = 9'h1A5;
    score_vld_in = 1'b1;
    @(negedge clk);
    score_vld_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({vld_mst_out, data_mst_out} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL mid_byte0 got vld=%b data=%h want vld=1 data=a5", vld_mst_out, data_mst_out); end
    rdy_mst_in = 1'b1;
    @(negedge clk);
    rdy_mst_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({vld_mst_out, data_mst_out} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL mid_byte1_hold got vld=%b data=%h want vld=1 data=41", vld_mst_out, data_mst_out); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({vld_mst_out, credit_out, data_mst_out} !== {1'b0, 4'd4, 8'h00}) begin n_fail++; $display("FAIL mid_reset got vld=%b credit=%0d data=%h want vld=0 credit=4 data=00", vld_mst_out, credit_out, data_mst_out); end
    score_in = 9'h0FF;
    score_vld_in = 1'b1;
    rdy_mst_in = 1'b1;
    @(negedge clk);
    score_vld_in = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({vld_mst_out, data_mst_out} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL mid_restart_b0 got vld=%b data=%h want vld=1 data=ff", vld_mst_out, data_mst_out); end
    @(negedge clk);
    n_tests++;
    if ({vld_mst_out, data_mst_out} !== {1'b1, 8'h40}) begin n_fail++; $display("FAIL mid_restart_b1 got vld=%b data=%h want vld=1 data=40", vld_mst_out, data_mst_out); end
    @(negedge clk);
    n_tests++;
    if ({vld_mst_out, credit_out} !== {1'b0, 4'd4}) begin n_fail++; $display("FAIL mid_restart_done got vld=%b credit=%0d want vld=0 credit=4", vld_mst_out, credit_out); end
    rdy_mst_in = 1'b0;
  endtask

`ifdef ATTN_TX_SUM_EN
  task automatic test_sum;
    logic [7:0] exp [10] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h81};
    logic [7:0] got [$];
    do_reset();
    rdy_mst_in = 1'b1;
    score_in = 9'h040;
    for (int c = 0; c < 40; c++) begin
      if (vld_mst_out && rdy_mst_in) got.push_back(data_mst_out);
      score_vld_in = c < 4;
      @(negedge clk);
    end
    n_tests++;
    if (got.size() != 10) begin n_fail++; $display("FAIL sum_count got %0d bytes want 10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL sum_byte[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    rdy_mst_in = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure_overflow();
    test_reset_midframe();
`ifdef ATTN_TX_SUM_EN
    test_sum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
